vga_scan_generator: RTL

- Produces the raster scan position POS_X/POS_Y consumed by the GPU's per-pixel logic, including sprite area checks and sprite-ROM offset generation.
- Also produces VGA HSYNC/VSYNC, active-video and frame/line markers.
- Sits at the head of the graphics pipeline. It is fed by the system clock and divides it down to the pixel rate internally.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/pixel_tick_divider.sv | 24 ++
 rtl/vga_scan_generator.sv | 86 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, scan-total helpers and the shared coordinate type
package vga_timing_pkg;
    typedef logic [9:0] coord_t;
    localparam int CLK_DIV_DEF  = 2;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int COORD_LIMIT  = 1024;

    function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_window(input int pos, input int lo, input int len);
        return pos >= lo && pos < lo + len;
    endfunction
endpackage

// File: rtl/pixel_tick_divider.sv
// pixel_tick_divider: one-CLK pixel strobe every CLK_DIV system clocks
module pixel_tick_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic PIXEL_EN
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] r_cnt;
    logic         r_live;
    // Phase counter; r_live holds the strobe low in the cycle right after reset, which matters when CLK_DIV=1
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_live <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            r_live <= 1'b1;
        end
    end
    assign PIXEL_EN = r_live && (r_cnt == LAST);
endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: raster position, sync, active-video and line/frame markers at the pixel rate
module vga_scan_generator
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       PIXEL_EN,
    output logic [9:0] POS_X,
    output logic [9:0] POS_Y,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic       LINE_START,
    output logic       FRAME_START
);
    localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    generate
        if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT || CLK_DIV < 1) begin : g_bad_cfg
            $error("vga_scan_generator: totals must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    logic   w_pixel_en;
    coord_t w_nx, w_ny;
    coord_t r_x, r_y;
    logic   r_hs, r_vs, r_vid, r_ls, r_fs;

    pixel_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .PIXEL_EN (w_pixel_en)
    );

    // Next scan position: column wraps every line, line wraps on the last column of the last line
    always_comb begin
        w_nx = (r_x == H_LAST) ? '0 : r_x + 1'b1;
        w_ny = (r_x != H_LAST) ? r_y : (r_y == V_LAST) ? '0 : r_y + 1'b1;
    end

    // Position and its decodes load together from the next position so they never skew; markers last one CLK
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x   <= H_LAST;
            r_y   <= V_LAST;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_vid <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else if (w_pixel_en) begin
            r_x   <= w_nx;
            r_y   <= w_ny;
            r_hs  <= !in_window(int'(w_nx), H_ACTIVE + H_FP, H_SYNC);
            r_vs  <= !in_window(int'(w_ny), V_ACTIVE + V_FP, V_SYNC);
            r_vid <= in_window(int'(w_nx), 0, H_ACTIVE) && in_window(int'(w_ny), 0, V_ACTIVE);
            r_ls  <= w_nx == '0;
            r_fs  <= w_nx == '0 && w_ny == '0;
        end else begin
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end
    end

    assign PIXEL_EN    = w_pixel_en;
    assign POS_X       = r_x;
    assign POS_Y       = r_y;
    assign HSYNC       = r_hs;
    assign VSYNC       = r_vs;
    assign VIDEO_ON    = r_vid;
    assign LINE_START  = r_ls;
    assign FRAME_START = r_fs;
endmodule
